// File: rtl/banco_registradores_param_pkg.sv
// Shared constants and helpers for the parametrised register bank.
// Defaults, the hardwired-zero register index and per-port slice offsets.
package banco_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int REG_ZERO  = 0;

    // Low bit of port 'port' inside a flattened bus of 'width'-bit lanes.
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/banco_registradores_param_rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a running count.
// Reserve sets a bit, writeback clears it, flush clears everything.
module rf_scoreboard
    import banco_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    input  logic             flush,
    output logic [NREGS-1:0] busy_vec,
    output logic [AW:0]      cnt
);

    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic             wr_hit;
    logic             rsv_hit;
    logic             inc;
    logic             dec;
    logic [NREGS-1:0] busy_next;
    logic [AW:0]      cnt_next;

    assign wr_hit  = wr_en && (wr_addr != AW'(REG_ZERO)) && ({1'b0, wr_addr} < NREGS_W);
    assign rsv_hit = rsv_en && !flush && (rsv_addr != AW'(REG_ZERO))
                     && ({1'b0, rsv_addr} < NREGS_W);

    // Reserve is checked before clear so a same-address reserve wins.
    always_comb begin
        busy_next = busy_vec;
        inc       = 1'b0;
        dec       = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (flush)
                busy_next[i] = 1'b0;
            else if (rsv_hit && rsv_addr == AW'(i))
                busy_next[i] = 1'b1;
            else if (wr_hit && wr_addr == AW'(i))
                busy_next[i] = 1'b0;
            if (busy_next[i] && !busy_vec[i])
                inc = 1'b1;
            if (!busy_next[i] && busy_vec[i])
                dec = 1'b1;
        end
        if (flush)
            cnt_next = '0;
        else
            cnt_next = cnt + (AW+1)'(inc) - (AW+1)'(dec);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_vec <= '0;
            cnt      <= '0;
        end else begin
            busy_vec <= busy_next;
            cnt      <= cnt_next;
        end
    end

endmodule

// File: rtl/banco_registradores_param.sv
// Parametrised clocked register bank: NRD combinational read ports with
// write forwarding, one synchronous write port and a pending-write scoreboard.
module banco_registradores_param
    import banco_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int NREGS = NREGS_DEF,
    parameter  int NRD   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    input  logic                flush,
    output logic [AW:0]         pend_count
);

    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy_vec;
    logic             wr_hit;

    assign wr_hit = wr_en && (wr_addr != AW'(REG_ZERO)) && ({1'b0, wr_addr} < NREGS_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (wr_hit) begin
            for (int i = 0; i < NREGS; i++)
                if (wr_addr == AW'(i))
                    regs[i] <= wr_data;
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush),
        .busy_vec (busy_vec),
        .cnt      (pend_count)
    );

    // Out-of-range addresses fall through to zero exactly like x0.
    for (genvar p = 0; p < NRD; p++) begin : g_rd
        localparam int ALO = slice_lo(p, AW);
        localparam int DLO = slice_lo(p, XLEN);

        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            bsy;

        assign addr = rs_addr[ALO +: AW];

        always_comb begin
            data = '0;
            bsy  = 1'b0;
            if (addr != AW'(REG_ZERO) && {1'b0, addr} < NREGS_W) begin
                if (wr_en && wr_addr == addr) begin
                    data = wr_data;
                end else begin
                    for (int i = 0; i < NREGS; i++) begin
                        if (addr == AW'(i)) begin
                            data = regs[i];
                            bsy  = busy_vec[i];
                        end
                    end
                end
            end
        end

        assign rs_data[DLO +: XLEN] = data;
        assign rs_busy[p]           = bsy;
    end

endmodule

// File: tb/tb_banco_registradores_param.sv
// Self-checking bench for banco_registradores_param: a 32-entry/2-port bank
// and a 24-entry/3-port bank, with a queue of expected values per scenario.
module tb_banco_registradores_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [9:0]  rs_addr;
    logic [63:0] rs_data;
    logic [1:0]  rs_busy;
    logic        wr_en, rsv_en, flush;
    logic [4:0]  wr_addr, rsv_addr;
    logic [31:0] wr_data;
    logic [5:0]  pend_count;

    logic [14:0] rs_addr24;
    logic [95:0] rs_data24;
    logic [2:0]  rs_busy24;
    logic        wr_en24, rsv_en24, flush24;
    logic [4:0]  wr_addr24, rsv_addr24;
    logic [31:0] wr_data24;
    logic [5:0]  pend24;

    int          compared   = 0;
    int          mismatched = 0;
    logic [63:0] exp_q[$];
    logic [63:0] e;

    always #5 clk = ~clk;

    banco_registradores_param #(.XLEN(32), .NREGS(32), .NRD(2)) dut (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .flush(flush), .pend_count(pend_count)
    );

    banco_registradores_param #(.XLEN(32), .NREGS(24), .NRD(3)) dut24 (
        .clk(clk), .rst(rst), .rs_addr(rs_addr24), .rs_data(rs_data24), .rs_busy(rs_busy24),
        .wr_en(wr_en24), .wr_addr(wr_addr24), .wr_data(wr_data24), .rsv_en(rsv_en24),
        .rsv_addr(rsv_addr24), .flush(flush24), .pend_count(pend24)
    );

    task automatic drive_idle();
        wr_en = 0; rsv_en = 0; flush = 0; wr_addr = 0; rsv_addr = 0; wr_data = 0;
        wr_en24 = 0; rsv_en24 = 0; flush24 = 0; wr_addr24 = 0; rsv_addr24 = 0; wr_data24 = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; rsv_en = 1; rsv_addr = 6;
        @(negedge clk);
        drive_idle(); rs_addr = {5'd6, 5'd5};
        #1;
        exp_q.push_back(64'h0000_0000_DEAD_BEEF); exp_q.push_back(64'd1); exp_q.push_back(64'd1);
        e = exp_q.pop_front(); compared++;
        if (64'(rs_data[31:0]) !== e) begin mismatched++; $display("[TB] FAIL reset_pre_x5 got=%h exp=%h", rs_data[31:0], e); end
        e = exp_q.pop_front(); compared++;
        if (64'(rs_busy[1]) !== e) begin mismatched++; $display("[TB] FAIL reset_pre_busy6 got=%h exp=%h", rs_busy[1], e); end
        e = exp_q.pop_front(); compared++;
        if (64'(pend_count) !== e) begin mismatched++; $display("[TB] FAIL reset_pre_pend got=%0d exp=%0d", pend_count, e); end
        rst = 1;
        #1;
        exp_q.push_back(64'd0); exp_q.push_back(64'd0); exp_q.push_back(64'd0);
        e = exp_q.pop_front(); compared++;
        if (64'(rs_data) !== e) begin mismatched++; $display("[TB] FAIL reset_data got=%h exp=%h", rs_data, e); end
        e = exp_q.pop_front(); compared++;
        if (64'(rs_busy) !== e) begin mismatched++; $display("[TB] FAIL reset_busy got=%h exp=%h", rs_busy, e); end
        e = exp_q.pop_front(); compared++;
        if (64'(pend_count) !== e) begin mismatched++; $display("[TB] FAIL reset_pend got=%0d exp=%0d", pend_count, e); end
        @(negedge clk); rst = 0;
        @(negedge clk); #1;
        exp_q.push_back(64'd0);
        e = exp_q.pop_front(); compared++;
        if (64'(rs_data[31:0]) !== e) begin mismatched++; $display("[TB] FAIL reset_post_x5 got=%h exp=%h", rs_data[31:0], e); end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        wr_en = 1; wr_addr = 3; wr_data = 32'h12345678;
        @(negedge clk);
        drive_idle(); rs_addr = {5'd0, 5'd3};
        #1;
        exp_q.push_back(64'h0000_0000_1234_5678); exp_q.push_back(64'd0);
        e = exp_q.pop_front(); compared++;
        if (64'(rs_data[31:0]) !== e) begin mismatched++; $display("[TB] FAIL wr_x3 got=%h exp=%h", rs_data[31:0], e); end
        e = exp_q.pop_front(); compared++;
        if (64'(rs_data[63:32]) !== e) begin mismatched++; $display("[TB] FAIL rd_x0 got=%h exp=%h", rs_data[63:32], e); end
        @(negedge clk);
        wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; rsv_en = 1; rsv_addr = 0;
        #1;
        exp_q.push_back(64'd0);
        e = exp_q.pop_front(); compared++;
        if (64'(rs_data[63:32]) !== e) begin mismatched++; $display("[TB] FAIL x0_no_forward got=%h exp=%h", rs_data[63:32], e); end
        @(negedge clk);
        drive_idle(); #1;
        exp_q.push_back(64'd0); exp_q.push_back(64'd0);
        e = exp_q.pop_front(); compared++;
        if (64'(rs_data[63:32]) !== e) begin mismatched++; $display("[TB] FAIL x0_after_write got=%h exp=%h", rs_data[63:32], e); end
        e = exp_q.pop_front(); compared++;
        if (64'(pend_count) !== e) begin mismatched++; $display("[TB] FAIL x0_reserve_pend got=%0d exp=%0d", pend_count, e); end
    endtask

    task automatic test_forwarding();
        @(negedge clk);
        rsv_en = 1; rsv_addr = 7;
        @(negedge clk);
        drive_idle(); rs_addr = {5'd7, 5'd0};
        #1;
        exp_q.push_back(64'd1); exp_q.push_back(64'd1);
        e = exp_q.pop_front(); compared++;
        if (64'(rs_busy[1]) !== e) begin mismatched++; $display("[TB] FAIL fwd_pre_busy got=%h exp=%h", rs_busy[1], e); end
        e = exp_q.pop_front(); compared++;
        if (64'(pend_count) !== e) begin mismatched++; $display("[TB] FAIL fwd_pre_pend got=%0d exp=%0d", pend_count, e); end
        wr_en = 1; wr_addr = 7; wr_data = 32'hA5A5A5A5;
        #1;
        exp_q.push_back(64'h0000_0000_A5A5_A5A5); exp_q.push_back(64'd0);
        e = exp_q.pop_front(); compared++;
        if (64'(rs_data[63:32]) !== e) begin mismatched++; $display("[TB] FAIL fwd_data got=%h exp=%h", rs_data[63:32], e); end
        e = exp_q.pop_front(); compared++;
        if (64'(rs_busy[1]) !== e) begin mismatched++; $display("[TB] FAIL fwd_busy got=%h exp=%h", rs_busy[1], e); end
        @(negedge clk);
        drive_idle(); #1;
        exp_q.push_back(64'h0000_0000_A5A5_A5A5); exp_q.push_back(64'd0); exp_q.push_back(64'd0);
        e = exp_q.pop_front(); compared++;
        if (64'(rs_data[63:32]) !== e) begin mismatched++; $display("[TB] FAIL fwd_stored got=%h exp=%h", rs_data[63:32], e); end
        e = exp_q.pop_front(); compared++;
        if (64'(rs_busy[1]) !== e) begin mismatched++; $display("[TB] FAIL fwd_post_busy got=%h exp=%h", rs_busy[1], e); end
        e = exp_q.pop_front(); compared++;
        if (64'(pend_count) !== e) begin mismatched++; $display("[TB] FAIL fwd_post_pend got=%0d exp=%0d", pend_count, e); end
    endtask

    task automatic test_scoreboard();
        logic [4:0] seq_addr [4];
        int         seq_pend [4];
        seq_addr = '{5'd1, 5'd2, 5'd2, 5'd31};
        seq_pend = '{1, 2, 2, 3};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rsv_en = 1; rsv_addr = seq_addr[k];
            exp_q.push_back(64'(seq_pend[k]));
            @(negedge clk);
            drive_idle();
            e = exp_q.pop_front(); compared++;
            if (64'(pend_count) !== e) begin mismatched++; $display("[TB] FAIL sb_pend_step%0d got=%0d exp=%0d", k, pend_count, e); end
        end
        rs_addr = {5'd31, 5'd2};
        wr_en = 1; wr_addr = 2; wr_data = 32'h0000BEEF; rsv_en = 1; rsv_addr = 2;
        @(negedge clk);
        drive_idle(); #1;
        exp_q.push_back(64'd1); exp_q.push_back(64'd3); exp_q.push_back(64'h0000_0000_0000_BEEF);
        e = exp_q.pop_front(); compared++;
        if (64'(rs_busy[0]) !== e) begin mismatched++; $display("[TB] FAIL sb_wr_rsv_busy got=%h exp=%h", rs_busy[0], e); end
        e = exp_q.pop_front(); compared++;
        if (64'(pend_count) !== e) begin mismatched++; $display("[TB] FAIL sb_wr_rsv_pend got=%0d exp=%0d", pend_count, e); end
        e = exp_q.pop_front(); compared++;
        if (64'(rs_data[31:0]) !== e) begin mismatched++; $display("[TB] FAIL sb_wr_rsv_data got=%h exp=%h", rs_data[31:0], e); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        flush = 1; rsv_en = 1; rsv_addr = 4; wr_en = 1; wr_addr = 9; wr_data = 32'h55;
        @(negedge clk);
        drive_idle(); rs_addr = {5'd9, 5'd4};
        #1;
        exp_q.push_back(64'd0); exp_q.push_back(64'd0); exp_q.push_back(64'h55);
        e = exp_q.pop_front(); compared++;
        if (64'(pend_count) !== e) begin mismatched++; $display("[TB] FAIL flush_pend got=%0d exp=%0d", pend_count, e); end
        e = exp_q.pop_front(); compared++;
        if (64'(rs_busy[0]) !== e) begin mismatched++; $display("[TB] FAIL flush_busy4 got=%h exp=%h", rs_busy[0], e); end
        e = exp_q.pop_front(); compared++;
        if (64'(rs_data[63:32]) !== e) begin mismatched++; $display("[TB] FAIL flush_x9 got=%h exp=%h", rs_data[63:32], e); end
        rs_addr = {5'd31, 5'd2};
        #1;
        exp_q.push_back(64'd0);
        e = exp_q.pop_front(); compared++;
        if (64'(rs_busy) !== e) begin mismatched++; $display("[TB] FAIL flush_busy_x2_x31 got=%h exp=%h", rs_busy, e); end
    endtask

    task automatic test_non_pow2();
        @(negedge clk);
        wr_en24 = 1; wr_addr24 = 1; wr_data24 = 32'h11111111;
        @(negedge clk);
        wr_addr24 = 23; wr_data24 = 32'h23232323;
        @(negedge clk);
        wr_addr24 = 30; wr_data24 = 32'hFFFFFFFF; rsv_en24 = 1; rsv_addr24 = 30;
        rs_addr24 = {5'd0, 5'd0, 5'd30};
        #1;
        exp_q.push_back(64'd0); exp_q.push_back(64'd0);
        e = exp_q.pop_front(); compared++;
        if (64'(rs_data24[31:0]) !== e) begin mismatched++; $display("[TB] FAIL np2_oor_forward got=%h exp=%h", rs_data24[31:0], e); end
        e = exp_q.pop_front(); compared++;
        if (64'(rs_busy24[0]) !== e) begin mismatched++; $display("[TB] FAIL np2_oor_busy got=%h exp=%h", rs_busy24[0], e); end
        @(negedge clk);
        drive_idle(); rs_addr24 = {5'd0, 5'd23, 5'd1};
        #1;
        exp_q.push_back(64'h1111_1111); exp_q.push_back(64'h2323_2323); exp_q.push_back(64'd0); exp_q.push_back(64'd0);
        e = exp_q.pop_front(); compared++;
        if (64'(rs_data24[31:0]) !== e) begin mismatched++; $display("[TB] FAIL np2_p0_x1 got=%h exp=%h", rs_data24[31:0], e); end
        e = exp_q.pop_front(); compared++;
        if (64'(rs_data24[63:32]) !== e) begin mismatched++; $display("[TB] FAIL np2_p1_x23 got=%h exp=%h", rs_data24[63:32], e); end
        e = exp_q.pop_front(); compared++;
        if (64'(rs_data24[95:64]) !== e) begin mismatched++; $display("[TB] FAIL np2_p2_x0 got=%h exp=%h", rs_data24[95:64], e); end
        e = exp_q.pop_front(); compared++;
        if (64'(pend24) !== e) begin mismatched++; $display("[TB] FAIL np2_pend got=%0d exp=%0d", pend24, e); end
        rs_addr24 = {5'd24, 5'd30, 5'd6};
        rsv_en24 = 1; rsv_addr24 = 23;
        #1;
        exp_q.push_back(64'd0);
        e = exp_q.pop_front(); compared++;
        if (64'(rs_data24) !== e) begin mismatched++; $display("[TB] FAIL np2_oor_reads got=%h exp=%h", rs_data24, e); end
        @(negedge clk);
        drive_idle(); rs_addr24 = {5'd0, 5'd23, 5'd1};
        #1;
        exp_q.push_back(64'b010); exp_q.push_back(64'd1);
        e = exp_q.pop_front(); compared++;
        if (64'(rs_busy24) !== e) begin mismatched++; $display("[TB] FAIL np2_busy_x23 got=%b exp=%b", rs_busy24, e[2:0]); end
        e = exp_q.pop_front(); compared++;
        if (64'(pend24) !== e) begin mismatched++; $display("[TB] FAIL np2_pend_x23 got=%0d exp=%0d", pend24, e); end
    endtask

    task automatic test_random();
        logic [31:0] m_regs [32];
        logic        m_busy [32];
        int          pc;
        logic [4:0]  a;
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            wr_en    = 1'($urandom_range(0, 1));
            wr_addr  = 5'($urandom_range(0, 31));
            wr_data  = $urandom;
            rsv_en   = 1'($urandom_range(0, 1));
            rsv_addr = 5'($urandom_range(0, 31));
            flush    = ($urandom_range(0, 15) == 0);
            rs_addr  = 10'($urandom);
            if (n % 4 == 0) rs_addr[9:5] = wr_addr;
            #1;
            for (int p = 0; p < 2; p++) begin
                a = rs_addr[p*5 +: 5];
                if (a == 0) begin
                    exp_q.push_back(64'd0); exp_q.push_back(64'd0);
                end else if (wr_en && wr_addr == a) begin
                    exp_q.push_back(64'(wr_data)); exp_q.push_back(64'd0);
                end else begin
                    exp_q.push_back(64'(m_regs[a])); exp_q.push_back(64'(m_busy[a]));
                end
            end
            pc = 0;
            for (int i = 0; i < 32; i++) pc += int'(m_busy[i]);
            exp_q.push_back(64'(pc));
            for (int p = 0; p < 2; p++) begin
                e = exp_q.pop_front(); compared++;
                if (64'(rs_data[p*32 +: 32]) !== e) begin mismatched++; $display("[TB] FAIL rnd_data it%0d p%0d got=%h exp=%h", n, p, rs_data[p*32 +: 32], e); end
                e = exp_q.pop_front(); compared++;
                if (64'(rs_busy[p]) !== e) begin mismatched++; $display("[TB] FAIL rnd_busy it%0d p%0d got=%h exp=%h", n, p, rs_busy[p], e); end
            end
            e = exp_q.pop_front(); compared++;
            if (64'(pend_count) !== e) begin mismatched++; $display("[TB] FAIL rnd_pend it%0d got=%0d exp=%0d", n, pend_count, e); end
            if (wr_en && wr_addr != 0) begin m_regs[wr_addr] = wr_data; m_busy[wr_addr] = 1'b0; end
            if (flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else if (rsv_en && rsv_addr != 0) begin
                m_busy[rsv_addr] = 1'b1;
            end
        end
        @(negedge clk);
        drive_idle();
    endtask

    initial begin
        drive_idle();
        rs_addr = '0; rs_addr24 = '0;
        repeat (2) @(negedge clk);
        rst = 0;
        test_reset();
        test_write_read();
        test_forwarding();
        test_scoreboard();
        test_flush();
        test_non_pow2();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
